// File: rtl/conv3_window_ctrl.sv
// -----------------------------------------------------------------------------
// conv3_window_ctrl
//
// Frame-level controller for a 3x3 line-buffer window datapath. It accepts a
// raster-order pixel stream under a valid/ready handshake, drives the
// line-buffer shift enable and tracks the column/row position of every
// accepted pixel. Win_Valid is raised only when the 3x3 window holds a
// complete in-frame neighbourhood, so windows that span a row boundary, or
// that still contain stale pixels from a previous frame, never reach
// downstream.
//
// Optional feature (macro WIN_CENTER_COORD_EN): adds Win_Col / Win_Row, the
// registered window-center coordinates aligned with Win_Valid.
//
// Ports:
//   CLK        in   clock, rising edge
//   CLR        in   asynchronous active-high reset
//   Start      in   frame start request, sampled only in IDLE
//   Pix_Valid  in   upstream pixel present
//   Pix_Ready  out  controller accepts a pixel (combinational)
//   Shift_EN   out  line-buffer write/shift enable = Pix_Valid & Pix_Ready
//   Win_Valid  out  window outputs form a valid 3x3 window (registered)
//   Out_Ready  in   downstream consumes the window when Win_Valid & Out_Ready
//   Busy       out  high while a frame is in RUN or DRAIN
//   Frame_Done out  one-cycle pulse after the last window is consumed
//   Win_Col    out  window center column (WIN_CENTER_COORD_EN only)
//   Win_Row    out  window center row    (WIN_CENTER_COORD_EN only)
// -----------------------------------------------------------------------------
module conv3_window_ctrl #(
  parameter int IMG_Width  = 5,
  parameter int IMG_Height = 5,
  parameter int CW         = $clog2(IMG_Width),
  parameter int RW         = $clog2(IMG_Height)
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          Start,
  input  logic          Pix_Valid,
  output logic          Pix_Ready,
  output logic          Shift_EN,
  output logic          Win_Valid,
  input  logic          Out_Ready,
  output logic          Busy,
  output logic          Frame_Done
`ifdef WIN_CENTER_COORD_EN
  ,
  output logic [CW-1:0] Win_Col,
  output logic [RW-1:0] Win_Row
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_Width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_Height - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] col_r;
  logic [CW-1:0] col_nxt_s;
  logic [RW-1:0] row_r;
  logic [RW-1:0] row_nxt_s;
  logic          win_valid_r;
  logic          win_valid_nxt_s;

  logic          pix_ready_s;
  logic          accept_s;
  logic          col_last_s;
  logic          last_pix_s;
  logic          qual_s;

  // A pending window that downstream has not taken blocks shifting, since a
  // shift would overwrite the window data still being presented.
  assign pix_ready_s = (state_r == ST_RUN) && !(win_valid_r && !Out_Ready);
  assign accept_s    = Pix_Valid && pix_ready_s;
  assign col_last_s  = (col_r == COL_LAST);
  assign last_pix_s  = col_last_s && (row_r == ROW_LAST);
  // Accepts at Col<2 or Row<2 leave the window straddling a row wrap or
  // holding rows from before this frame, so only later positions qualify.
  assign qual_s      = accept_s && (col_r >= COL_MIN) && (row_r >= ROW_MIN);

  assign Pix_Ready  = pix_ready_s;
  assign Shift_EN   = accept_s;
  assign Win_Valid  = win_valid_r;
  assign Busy       = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign Frame_Done = (state_r == ST_DONE);

  // Next-state, position counters and window-valid qualification.
  always_comb begin
    state_nxt_s     = state_r;
    col_nxt_s       = col_r;
    row_nxt_s       = row_r;
    win_valid_nxt_s = win_valid_r;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          state_nxt_s     = ST_RUN;
          col_nxt_s       = {CW{1'b0}};
          row_nxt_s       = {RW{1'b0}};
          win_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s     = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s) begin
          if (last_pix_s) begin
            // Counters are parked at the origin rather than letting Row
            // step past the frame height.
            state_nxt_s = ST_DRAIN;
            col_nxt_s   = {CW{1'b0}};
            row_nxt_s   = {RW{1'b0}};
          end else if (col_last_s) begin
            col_nxt_s   = {CW{1'b0}};
            row_nxt_s   = row_r + RW'(1);
          end else begin
            col_nxt_s   = col_r + CW'(1);
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
        // A consume in the same cycle as a qualifying accept keeps the
        // strobe high so windows can stream back to back.
        if (qual_s) begin
          win_valid_nxt_s = 1'b1;
        end else if (Out_Ready) begin
          win_valid_nxt_s = 1'b0;
        end else begin
          win_valid_nxt_s = win_valid_r;
        end
      end
      ST_DRAIN: begin
        if (!win_valid_r || Out_Ready) begin
          state_nxt_s     = ST_DONE;
          win_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s     = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s     = ST_IDLE;
        col_nxt_s       = {CW{1'b0}};
        row_nxt_s       = {RW{1'b0}};
        win_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, counter and window-valid registers.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_r     <= ST_IDLE;
      col_r       <= {CW{1'b0}};
      row_r       <= {RW{1'b0}};
      win_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      col_r       <= col_nxt_s;
      row_r       <= row_nxt_s;
      win_valid_r <= win_valid_nxt_s;
    end
  end

`ifdef WIN_CENTER_COORD_EN
  logic [CW-1:0] win_col_r;
  logic [RW-1:0] win_row_r;

  // Window center is one pixel up and left of the qualifying accept; the
  // value is only loaded with a new window, so it holds through a stall.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      win_col_r <= {CW{1'b0}};
      win_row_r <= {RW{1'b0}};
    end else if (qual_s) begin
      win_col_r <= col_r - CW'(1);
      win_row_r <= row_r - RW'(1);
    end else begin
      win_col_r <= win_col_r;
      win_row_r <= win_row_r;
    end
  end

  assign Win_Col = win_col_r;
  assign Win_Row = win_row_r;
`endif

endmodule

// File: tb/tb_conv3_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_conv3_window_ctrl
//
// Directed bench for conv3_window_ctrl on a 5x5 frame. Each frame is driven
// cycle by cycle from bit masks (Pix_Valid, Out_Ready, Start per cycle) and
// the observed Win_Valid / Shift_EN / Frame_Done activity is collected into
// masks that are compared against hand-derived constants. Cycle 0 is the
// first cycle in RUN (the cycle after Start is sampled).
// -----------------------------------------------------------------------------
module tb_conv3_window_ctrl;

  logic       clk;
  logic       clr;
  logic       start;
  logic       pix_valid;
  logic       pix_ready;
  logic       shift_en;
  logic       win_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_done;
`ifdef WIN_CENTER_COORD_EN
  logic [2:0] win_col;
  logic [2:0] win_row;
`endif

  int n_cmp;
  int n_mis;

  conv3_window_ctrl #(
    .IMG_Width  (5),
    .IMG_Height (5)
  ) dut (
    .CLK        (clk),
    .CLR        (clr),
    .Start      (start),
    .Pix_Valid  (pix_valid),
    .Pix_Ready  (pix_ready),
    .Shift_EN   (shift_en),
    .Win_Valid  (win_valid),
    .Out_Ready  (out_ready),
    .Busy       (busy),
    .Frame_Done (frame_done)
`ifdef WIN_CENTER_COORD_EN
    ,
    .Win_Col    (win_col),
    .Win_Row    (win_row)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame: Start in the cycle before cycle 0 (with Pix_Valid high,
  // which must not be accepted), then ncyc cycles from the stimulus masks.
  task automatic run_frame(input string tag, input int ncyc,
                           input logic [63:0] pv_m, input logic [63:0] or_m,
                           input logic [63:0] st_m, input logic [63:0] exp_wv,
                           input logic [63:0] exp_sh, input logic [63:0] exp_fd);
    logic [63:0] wv_m;
    logic [63:0] sh_m;
    logic [63:0] fd_m;
    int          n_consume;
    int          n_viol;
`ifdef WIN_CENTER_COORD_EN
    int          n_coord_bad;
    logic        stalled;
    logic [2:0]  prev_col;
    logic [2:0]  prev_row;
    n_coord_bad = 0;
    stalled     = 1'b0;
    prev_col    = 3'd0;
    prev_row    = 3'd0;
`endif
    wv_m      = 64'd0;
    sh_m      = 64'd0;
    fd_m      = 64'd0;
    n_consume = 0;
    n_viol    = 0;

    @(negedge clk);
    start     = 1'b1;
    pix_valid = 1'b1;
    out_ready = 1'b1;
    #2;
    check_val({tag, "_start_ready"}, 64'(pix_ready), 64'd0);
    check_val({tag, "_start_shift"}, 64'(shift_en), 64'd0);

    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start     = st_m[c];
      pix_valid = pv_m[c];
      out_ready = or_m[c];
      #2;
      wv_m[c] = win_valid;
      sh_m[c] = shift_en;
      fd_m[c] = frame_done;
      if (win_valid && out_ready) begin
`ifdef WIN_CENTER_COORD_EN
        // k-th consumed window is centered at (k%3+1, k/3+1)
        if ((win_col != 3'(n_consume % 3 + 1)) || (win_row != 3'(n_consume / 3 + 1))) begin
          n_coord_bad = n_coord_bad + 1;
        end
`endif
        n_consume = n_consume + 1;
      end
      if (shift_en !== (pix_valid & pix_ready)) begin
        n_viol = n_viol + 1;
      end
      if (win_valid && !out_ready && pix_ready) begin
        n_viol = n_viol + 1;
      end
`ifdef WIN_CENTER_COORD_EN
      if (stalled && ((win_col != prev_col) || (win_row != prev_row))) begin
        n_coord_bad = n_coord_bad + 1;
      end
      stalled  = win_valid && !out_ready;
      prev_col = win_col;
      prev_row = win_row;
`endif
    end

    check_val({tag, "_win_valid_trace"}, wv_m, exp_wv);
    check_val({tag, "_shift_trace"}, sh_m, exp_sh);
    check_val({tag, "_frame_done_trace"}, fd_m, exp_fd);
    check_val({tag, "_windows"}, 64'(n_consume), 64'd9);
    check_val({tag, "_handshake_viol"}, 64'(n_viol), 64'd0);
    check_val({tag, "_idle_busy"}, 64'(busy), 64'd0);
`ifdef WIN_CENTER_COORD_EN
    check_val({tag, "_coord_errors"}, 64'(n_coord_bad), 64'd0);
`endif
  endtask

  // Nominal 5x5 expectations: windows after accepts 13-15, 18-20, 23-25.
  localparam logic [63:0] NOM_WV = 64'h0000_0000_039C_E000;
  localparam logic [63:0] NOM_SH = 64'h0000_0000_01FF_FFFF;
  localparam logic [63:0] NOM_FD = 64'h0000_0000_0400_0000;
  // Out_Ready low in cycles 13-16 stretches the frame by four cycles.
  localparam logic [63:0] BP_OR  = 64'hFFFF_FFFF_FFFE_1FFF;
  localparam logic [63:0] BP_WV  = 64'h0000_0000_39CF_E000;
  localparam logic [63:0] BP_SH  = 64'h0000_0000_1FFE_1FFF;
  localparam logic [63:0] BP_FD  = 64'h0000_0000_4000_0000;
  // Pix_Valid on even cycles only: accept a happens in cycle 2a.
  localparam logic [63:0] GAP_PV = 64'h5555_5555_5555_5555;
  localparam logic [63:0] GAP_WV = 64'h0002_A0A8_2A00_0000;
  localparam logic [63:0] GAP_SH = 64'h0001_5555_5555_5555;
  localparam logic [63:0] GAP_FD = 64'h0004_0000_0000_0000;
  // Start pulses in cycle 5 (RUN) and cycle 25 (DRAIN).
  localparam logic [63:0] ST_IGN = 64'h0000_0000_0200_0020;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    clr       = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b1;
    out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("rst_pix_ready", 64'(pix_ready), 64'd0);
    check_val("rst_shift_en", 64'(shift_en), 64'd0);
    check_val("rst_win_valid", 64'(win_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_frame_done", 64'(frame_done), 64'd0);
`ifdef WIN_CENTER_COORD_EN
    check_val("rst_win_col", 64'(win_col), 64'd0);
    check_val("rst_win_row", 64'(win_row), 64'd0);
`endif
    clr = 1'b0;

    run_frame("nominal", 28, ONES, ONES, 64'd0, NOM_WV, NOM_SH, NOM_FD);
    run_frame("backpressure", 32, ONES, BP_OR, 64'd0, BP_WV, BP_SH, BP_FD);
    run_frame("gapped", 52, GAP_PV, ONES, 64'd0, GAP_WV, GAP_SH, GAP_FD);
    run_frame("start_ignored", 28, ONES, ONES, ST_IGN, NOM_WV, NOM_SH, NOM_FD);

    // Mid-frame reset after the 16th accept, checked between clock edges.
    @(negedge clk);
    start     = 1'b1;
    pix_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    check_val("pre_clr_busy", 64'(busy), 64'd1);
    check_val("pre_clr_pix_ready", 64'(pix_ready), 64'd1);
    clr = 1'b1;
    #1;
    check_val("clr_busy", 64'(busy), 64'd0);
    check_val("clr_pix_ready", 64'(pix_ready), 64'd0);
    check_val("clr_shift_en", 64'(shift_en), 64'd0);
    check_val("clr_win_valid", 64'(win_valid), 64'd0);
    check_val("clr_frame_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    clr = 1'b0;

    run_frame("post_clr", 28, ONES, ONES, 64'd0, NOM_WV, NOM_SH, NOM_FD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/conv3_window_ctrl.md
# conv3_window_ctrl

Frame-level controller for the 3x3 line-buffer window datapath. Accepts a raster-order pixel stream under a valid/ready handshake and drives the line-buffer write/shift enable. Tracks row and column position and asserts a window-valid strobe only when the 3x3 window holds a complete, in-frame neighbourhood. It replaces a fixed-delay valid pipeline with position-exact qualification, downstream backpressure and frame start/done sequencing.

## Interface
- IMG_Width, 5: pixels per row, at least 3.
- IMG_Height, 5: rows per frame, at least 3.
- CW, $clog2(IMG_Width): column counter width.
- RW, $clog2(IMG_Height): row counter width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  asynchronous, active-high reset.
- Start  in  1  frame start request; sampled only in IDLE.
- Pix_Valid  in  1  upstream pixel present.
- Pix_Ready  out  1  controller accepts a pixel; combinational.
- Shift_EN  out  1  line-buffer WE; equals Pix_Valid & Pix_Ready; combinational.
- Win_Valid  out  1  line-buffer window outputs form a valid 3x3 window; registered.
- Out_Ready  in  1  downstream consumes the window when Win_Valid & Out_Ready.
- Busy  out  1  high in RUN and DRAIN.
- Frame_Done  out  1  one-cycle pulse after the last window is consumed.

## Operation
- State machine: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on Start. Clears Col, Row and Win_Valid.
  - RUN: a pixel is accepted on each cycle with Shift_EN high. After the acceptance at Col=IMG_Width-1, Row=IMG_Height-1, go to DRAIN.
  - DRAIN: wait until Win_Valid=0, or until Win_Valid & Out_Ready; then go to DONE.
  - DONE: Frame_Done=1 for exactly one cycle, then IDLE.
- Pix_Ready = (state==RUN) & !(Win_Valid & !Out_Ready). A pending, unconsumed window blocks shifting, because a shift would overwrite it.
- On each accept, Col increments. At IMG_Width-1, Col wraps to 0 and Row increments. Row does not wrap within a frame.
- Window qualification: an accept at (Row>=2, Col>=2) sets Win_Valid on the next edge. The window center is at (Row-1, Col-1) of that accept.
- Win_Valid clears on the edge where Out_Ready=1 and no new qualifying accept occurs. A simultaneous consume and qualifying accept keeps Win_Valid=1, for back-to-back windows.
- Accepts at Col<2 (row wrap region) or Row<2 never raise Win_Valid. Windows spanning a row boundary are suppressed.
- Windows per frame: (IMG_Width-2)*(IMG_Height-2).
- Start outside IDLE is ignored. Start and Pix_Valid high in the same IDLE cycle: no pixel is accepted (Pix_Ready=0).
- Line-buffer contents are not cleared between frames. Qualification guarantees stale data never reaches a valid window.

## Timing
- Reset values: state IDLE, Col=0, Row=0, Win_Valid=0, Busy=0, Frame_Done=0, Pix_Ready=0, Shift_EN=0.
- CLR asserted mid-frame: all of the above take effect immediately. Any in-flight window is discarded with no Frame_Done.
- Latency: qualifying accept at edge N -> Win_Valid high after edge N. This is the same edge the line buffer shifts, so window data and Win_Valid align.
- Throughput: one pixel per cycle when Out_Ready is held high.
- Busy rises on the edge after Start and falls on the edge entering DONE.
- Minimum frame time with Out_Ready=1: 1 cycle (IDLE->RUN) + IMG_Width*IMG_Height accepts + 1 cycle DRAIN + 1 cycle DONE.

## Configuration
- WIN_CENTER_COORD_EN defined: adds outputs Win_Col [CW-1:0] and Win_Row [RW-1:0].
  - Both are registered with Win_Valid and hold the window center coordinates, (Col-1, Row-1) of the qualifying accept.
  - Both reset to 0 and hold their value while Win_Valid is stalled.
- Without the macro, these ports and registers do not exist. All other behaviour is identical.

## Test plan
- Nominal 5x5 frame, Pix_Valid=1, Out_Ready=1: Pix_Ready rises the cycle after Start. First Win_Valid follows the 13th accept. Exactly 9 Win_Valid cycles, in groups of 3 separated by 2 idle cycles. Frame_Done pulses once, then IDLE.
- Backpressure: Out_Ready=0 for 4 cycles at the first window. Win_Valid holds, Pix_Ready=0 and Shift_EN=0 throughout. Resuming Out_Ready=1 yields 9 windows total, none lost or duplicated.
- Gapped input: Pix_Valid toggles 1/0. Col and Row advance only on Shift_EN. Window count is still 9 and Win_Valid is never raised on idle cycles.
- Start pulsed during RUN and during DRAIN: ignored, counters undisturbed. Start with Pix_Valid=1 in IDLE: Shift_EN stays 0 that cycle.
- CLR asserted after the 16th accept: outputs drop to reset values without waiting for a clock. A new Start then yields a clean 9-window frame.
- With WIN_CENTER_COORD_EN: window coordinates run from (col1,row1) to (col3,row3) in raster order. Coordinates hold steady under an Out_Ready stall.
